gpio_bus_master: RTL and testbench

//  Bus initiator for the 2-bit-address GPIO register interface (we, a, wd, rd).

---
 rtl/gpio_bus_pkg.sv | 27 ++
 rtl/gpio_poll_timer.sv | 40 ++++
 rtl/gpio_bus_master.sv | 169 ++++++++++++++++
 tb/tb_gpio_bus_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bus_pkg.sv
// Shared encodings for the GPIO bus initiator: command opcodes, register
// addresses, controller states and the writability rule.
package gpio_bus_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;
  localparam logic [1:0] OP_POLL  = 2'b11;

  localparam logic [1:0] GPIO_IN1  = 2'b00;
  localparam logic [1:0] GPIO_IN2  = 2'b01;
  localparam logic [1:0] GPIO_OUT1 = 2'b10;
  localparam logic [1:0] GPIO_OUT2 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRBACK = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Only the OUT registers (upper half of the map) accept writes.
  function automatic logic is_writable(input logic [1:0] addr);
    return addr[1];
  endfunction

endpackage

// File: rtl/gpio_poll_timer.sv
// Poll sample counter: counts failed poll samples and flags the sample that
// would bring the count to TIMEOUT. Saturates at TIMEOUT, never wraps.
module gpio_poll_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear has priority, increment stops at TIMEOUT.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CW'(TIMEOUT))) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The sample being taken now is the TIMEOUT-th one.
  assign last_o = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/gpio_bus_master.sv
// Command-driven initiator for the 2-bit-address GPIO register bus. One
// command in flight; read, write, read-modify-write and poll-until-match,
// each answered by exactly one held response.
module gpio_bus_master
  import gpio_bus_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_addr,
  input  logic [WIDTH-1:0] cmd_wdata,
  input  logic [WIDTH-1:0] cmd_mask,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             we,
  output logic [1:0]       a,
  output logic [WIDTH-1:0] wd,
  input  logic [WIDTH-1:0] rd
);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             we_q, we_d;
  logic [1:0]       a_q, a_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic             accept;
  logic             poll_match;
  logic             poll_inc;
  logic             poll_last;

  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign poll_match = (((rd ^ wdata_q) & mask_q) == '0);

  // Count only failed samples while sitting in ACCESS; any other state
  // (including the response handshake) returns the counter to zero.
  gpio_poll_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_poll_timer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q != ST_ACCESS),
    .inc_i  (poll_inc),
    .last_o (poll_last)
  );

  // Controller next-state: we defaults low so it is only ever a one-cycle pulse.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    we_d       = 1'b0;
    a_d        = a_q;
    wd_d       = wd_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    poll_inc   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = cmd_op;
          wdata_d = cmd_wdata;
          mask_d  = cmd_mask;
          if (((cmd_op == OP_WRITE) || (cmd_op == OP_RMW)) && !is_writable(cmd_addr)) begin
            // Read-only target: answer immediately, bus untouched.
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = ST_RESP;
          end else begin
            a_d     = cmd_addr;
            wd_d    = cmd_wdata;
            we_d    = (cmd_op == OP_WRITE);
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        unique case (op_q)
          OP_READ: begin
            rsp_data_d = rd;
            rsp_err_d  = 1'b0;
            state_d    = ST_RESP;
          end
          OP_WRITE: begin
            rsp_data_d = wd_q;
            rsp_err_d  = 1'b0;
            state_d    = ST_RESP;
          end
          OP_RMW: begin
            wd_d    = (rd & ~mask_q) | (wdata_q & mask_q);
            we_d    = 1'b1;
            state_d = ST_WRBACK;
          end
          OP_POLL: begin
            // A match on the final sample still wins over the timeout.
            if (poll_match) begin
              rsp_data_d = rd;
              rsp_err_d  = 1'b0;
              state_d    = ST_RESP;
            end else begin
              poll_inc = 1'b1;
              if (poll_last) begin
                rsp_data_d = rd;
                rsp_err_d  = 1'b1;
                state_d    = ST_RESP;
              end
            end
          end
        endcase
      end
      ST_WRBACK: begin
        rsp_data_d = wd_q;
        rsp_err_d  = 1'b0;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State, bus and response registers; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_READ;
      wdata_q    <= '0;
      mask_q     <= '0;
      we_q       <= 1'b0;
      a_q        <= GPIO_IN1;
      wd_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      we_q       <= we_d;
      a_q        <= a_d;
      wd_q       <= wd_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign we        = we_q;
  assign a         = a_q;
  assign wd        = wd_q;

endmodule

// File: tb/tb_gpio_bus_master.sv
// Bench for gpio_bus_master with a behavioural GPIO register slave and a
// transaction-level reference model of the OUT registers.
module tb_gpio_bus_master;

  localparam int W = 32;
  localparam int T = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [1:0]    cmd_addr = 2'b00;
  logic [W-1:0]  cmd_wdata = '0;
  logic [W-1:0]  cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [W-1:0]  rsp_data;
  logic          rsp_err;
  logic          we;
  logic [1:0]    a;
  logic [W-1:0]  wd;
  logic [W-1:0]  rd;

  // Slave registers and input pins.
  logic [W-1:0]  gp_in1 = '0;
  logic [W-1:0]  gp_in2 = '0;
  logic [W-1:0]  gp_out1 = '0;
  logic [W-1:0]  gp_out2 = '0;

  // Reference copies of the OUT registers.
  logic [W-1:0]  m_out1 = '0;
  logic [W-1:0]  m_out2 = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpio_bus_master #(.WIDTH(W), .TIMEOUT(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_mask  (cmd_mask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .we        (we),
    .a         (a),
    .wd        (wd),
    .rd        (rd)
  );

  // GPIO slave: combinational read, write captured at the end of a we cycle.
  always_comb begin
    case (a)
      2'b00:   rd = gp_in1;
      2'b01:   rd = gp_in2;
      2'b10:   rd = gp_out1;
      default: rd = gp_out2;
    endcase
  end

  always @(posedge clk) begin
    if (we && a == 2'b10) gp_out1 <= wd;
    if (we && a == 2'b11) gp_out2 <= wd;
  end

  // Issue one command with rsp_ready high; measure latency (accept edge = 0)
  // and we activity. gp_in1 is set to sw_val right after edge sw_at.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] ad,
                         input logic [W-1:0] wdv, input logic [W-1:0] mk,
                         input int sw_at, input logic [W-1:0] sw_val,
                         output int lat, output logic [W-1:0] d, output logic e,
                         output int we_n, output logic [1:0] we_a);
    int guard;
    lat = -1; d = '0; e = 1'b0; we_n = 0; we_a = 2'b00;
    cmd_op = op; cmd_addr = ad; cmd_wdata = wdv; cmd_mask = mk; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc == sw_at) gp_in1 = sw_val;
      if (we) begin we_n++; we_a = a; end
      if (rsp_valid) begin lat = cyc + 1; d = rsp_data; e = rsp_err; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    $display("txn op=%0d addr=%0d wdata=%h mask=%h lat=%0d data=%h err=%0d we_cycles=%0d",
             op, ad, wdv, mk, lat, d, e, we_n);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready got=%b want=0", cmd_ready); end
    checks++; if ({we, a, wd} !== '0) begin failures++; $display("FAIL rst_bus got we=%b a=%b wd=%h want zeros", we, a, wd); end
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== '0) begin failures++; $display("FAIL rst_rsp got v=%b e=%b d=%h want zeros", rsp_valid, rsp_err, rsp_data); end
    reset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b want=1", cmd_ready); end
  endtask

  task automatic test_write();
    int lat, wn; logic [W-1:0] d; logic e; logic [1:0] wa;
    run_cmd(2'b01, 2'b10, 32'hDEADBEEF, '0, -1, '0, lat, d, e, wn, wa);
    m_out1 = 32'hDEADBEEF;
    checks++; if (lat !== 2) begin failures++; $display("FAIL wr_lat got=%0d want=2", lat); end
    checks++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin failures++; $display("FAIL wr_rsp got d=%h e=%b want DEADBEEF/0", d, e); end
    checks++; if (wn !== 1 || wa !== 2'b10) begin failures++; $display("FAIL wr_we got cycles=%0d a=%b want 1/10", wn, wa); end
    checks++; if (gp_out1 !== m_out1) begin failures++; $display("FAIL wr_out1 got=%h want=%h", gp_out1, m_out1); end
  endtask

  task automatic test_read();
    int lat, wn; logic [W-1:0] d; logic e; logic [1:0] wa;
    gp_in2 = 32'h12345678;
    run_cmd(2'b00, 2'b01, '0, '0, -1, '0, lat, d, e, wn, wa);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rd_lat got=%0d want=2", lat); end
    checks++; if (d !== 32'h12345678 || e !== 1'b0) begin failures++; $display("FAIL rd_rsp got d=%h e=%b want 12345678/0", d, e); end
    checks++; if (wn !== 0) begin failures++; $display("FAIL rd_we got cycles=%0d want=0", wn); end
  endtask

  task automatic test_rmw();
    int lat, wn; logic [W-1:0] d; logic e; logic [1:0] wa;
    run_cmd(2'b01, 2'b11, 32'hFFFF0000, '0, -1, '0, lat, d, e, wn, wa);
    m_out2 = 32'hFFFF0000;
    run_cmd(2'b10, 2'b11, 32'h0000ABCD, 32'h0000FFFF, -1, '0, lat, d, e, wn, wa);
    m_out2 = 32'hFFFFABCD;
    checks++; if (lat !== 3) begin failures++; $display("FAIL rmw_lat got=%0d want=3", lat); end
    checks++; if (d !== 32'hFFFFABCD || e !== 1'b0) begin failures++; $display("FAIL rmw_rsp got d=%h e=%b want FFFFABCD/0", d, e); end
    checks++; if (wn !== 1 || wa !== 2'b11) begin failures++; $display("FAIL rmw_we got cycles=%0d a=%b want 1/11", wn, wa); end
    checks++; if (gp_out2 !== m_out2) begin failures++; $display("FAIL rmw_out2 got=%h want=%h", gp_out2, m_out2); end
  endtask

  task automatic test_poll();
    int lat, wn; logic [W-1:0] d; logic e; logic [1:0] wa;
    // Bit0 rises after five failed samples -> match on sample 5.
    gp_in1 = 32'h0;
    run_cmd(2'b11, 2'b00, 32'h1, 32'h1, 5, 32'h1, lat, d, e, wn, wa);
    checks++; if (lat !== 7 || e !== 1'b0 || d !== 32'h1) begin failures++; $display("FAIL poll_match got lat=%0d e=%b d=%h want 7/0/1", lat, e, d); end
    // Never matches -> TIMEOUT samples, error.
    gp_in1 = 32'h0;
    run_cmd(2'b11, 2'b00, 32'h1, 32'h1, -1, '0, lat, d, e, wn, wa);
    checks++; if (lat !== T + 1 || e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL poll_timeout got lat=%0d e=%b d=%h want %0d/1/0", lat, e, d, T + 1); end
    // Match on the very last allowed sample still succeeds.
    gp_in1 = 32'h0;
    run_cmd(2'b11, 2'b00, 32'h1, 32'h1, T - 1, 32'h3, lat, d, e, wn, wa);
    checks++; if (lat !== T + 1 || e !== 1'b0 || d !== 32'h3) begin failures++; $display("FAIL poll_last got lat=%0d e=%b d=%h want %0d/0/3", lat, e, d, T + 1); end
    // Empty mask matches on the first sample.
    gp_in1 = 32'h5A5A0000;
    run_cmd(2'b11, 2'b00, 32'hFFFFFFFF, 32'h0, -1, '0, lat, d, e, wn, wa);
    checks++; if (lat !== 2 || e !== 1'b0 || d !== 32'h5A5A0000) begin failures++; $display("FAIL poll_mask0 got lat=%0d e=%b d=%h want 2/0/5A5A0000", lat, e, d); end
  endtask

  task automatic test_reject();
    int lat, wn; logic [W-1:0] d; logic e; logic [1:0] wa;
    run_cmd(2'b01, 2'b01, 32'hCAFEF00D, '0, -1, '0, lat, d, e, wn, wa);
    checks++; if (lat !== 1 || e !== 1'b1 || d !== '0) begin failures++; $display("FAIL rej_wr got lat=%0d e=%b d=%h want 1/1/0", lat, e, d); end
    checks++; if (wn !== 0) begin failures++; $display("FAIL rej_wr_we got cycles=%0d want=0", wn); end
    run_cmd(2'b10, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, '0, lat, d, e, wn, wa);
    checks++; if (lat !== 1 || e !== 1'b1 || wn !== 0) begin failures++; $display("FAIL rej_rmw got lat=%0d e=%b we=%0d want 1/1/0", lat, e, wn); end
    checks++; if (gp_out1 !== m_out1 || gp_out2 !== m_out2) begin failures++; $display("FAIL rej_outs got %h/%h want %h/%h", gp_out1, gp_out2, m_out1, m_out2); end
  endtask

  task automatic test_backpressure();
    int guard; logic [W-1:0] held;
    rsp_ready = 1'b0;
    cmd_op = 2'b00; cmd_addr = 2'b10; cmd_valid = 1'b1;
    @(posedge clk); #1;
    // Offer a second command that must wait, not vanish.
    cmd_op = 2'b01; cmd_addr = 2'b10; cmd_wdata = 32'h00000001;
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    held = rsp_data;
    checks++; if (held !== m_out1 || rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_first got v=%b d=%h want 1/%h", rsp_valid, held, m_out1); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold cyc=%0d got v=%b d=%h rdy=%b want 1/%h/0", i, rsp_valid, rsp_data, cmd_ready, held);
      end
    end
    $display("txn op=0 addr=2 stalled response data=%h", held);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    m_out1 = 32'h00000001;
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    $display("txn op=1 addr=2 held command data=%h", m_out1);
    checks++; if (gp_out1 !== m_out1) begin failures++; $display("FAIL bp_held_cmd got out1=%h want=%h", gp_out1, m_out1); end
  endtask

  task automatic test_reset_mid_poll();
    int lat, wn; logic [W-1:0] d; logic e; logic [1:0] wa;
    gp_in2 = 32'h0;
    cmd_op = 2'b11; cmd_addr = 2'b01; cmd_wdata = 32'h80000000; cmd_mask = 32'h80000000; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b want=0", cmd_ready); end
    @(posedge clk); #1;
    checks++; if ({we, a, wd} !== '0 || {rsp_valid, rsp_err, rsp_data} !== '0) begin
      failures++; $display("FAIL mid_rst_outs got we=%b a=%b wd=%h v=%b e=%b d=%h want zeros", we, a, wd, rsp_valid, rsp_err, rsp_data);
    end
    reset = 1'b0;
    $display("txn reset during poll");
    // Fresh poll after reset must get the full sample budget.
    gp_in1 = 32'h0;
    run_cmd(2'b11, 2'b00, 32'h1, 32'h1, -1, '0, lat, d, e, wn, wa);
    checks++; if (lat !== T + 1 || e !== 1'b1) begin failures++; $display("FAIL post_rst_poll got lat=%0d e=%b want %0d/1", lat, e, T + 1); end
  endtask

  task automatic test_random();
    int lat, wn, n, exp_lat, exp_we, sw;
    logic [W-1:0] d, wdv, mk, cur, exp_d, mv, nm;
    logic e, exp_e;
    logic [1:0] wa, op, ad;
    for (int it = 0; it < 40; it++) begin
      op = 2'($urandom_range(0, 3));
      ad = 2'($urandom_range(0, 3));
      wdv = $urandom; mk = $urandom;
      gp_in1 = $urandom; gp_in2 = $urandom;
      sw = -1;
      case (ad)
        2'b00:   cur = gp_in1;
        2'b01:   cur = gp_in2;
        2'b10:   cur = m_out1;
        default: cur = m_out2;
      endcase
      exp_we = 0; exp_e = 1'b0; exp_lat = 2; exp_d = '0;
      if (op == 2'b00) begin
        exp_d = cur;
      end else if (op == 2'b01 || op == 2'b10) begin
        if (!ad[1]) begin
          exp_lat = 1; exp_e = 1'b1;
        end else begin
          exp_d = (op == 2'b01) ? wdv : ((cur & ~mk) | (wdv & mk));
          exp_lat = (op == 2'b01) ? 2 : 3;
          exp_we = 1;
          if (ad == 2'b10) m_out1 = exp_d; else m_out2 = exp_d;
        end
      end else begin
        ad = 2'b00;
        mk = mk | 32'h1;
        mv = ($urandom & ~mk) | (wdv & mk);
        nm = mv ^ (mk & (~mk + 1));
        gp_in1 = nm;
        n = $urandom_range(0, T);
        if (n < T) begin
          sw = n; exp_lat = 2 + n; exp_d = mv;
        end else begin
          exp_lat = T + 1; exp_d = nm; exp_e = 1'b1;
        end
      end
      run_cmd(op, ad, wdv, mk, sw, mv, lat, d, e, wn, wa);
      checks++; if (lat !== exp_lat || d !== exp_d || e !== exp_e) begin
        failures++; $display("FAIL rand_rsp it=%0d op=%0d got lat=%0d d=%h e=%b want %0d/%h/%b", it, op, lat, d, e, exp_lat, exp_d, exp_e);
      end
      checks++; if (wn !== exp_we || gp_out1 !== m_out1 || gp_out2 !== m_out2) begin
        failures++; $display("FAIL rand_bus it=%0d got we=%0d outs=%h/%h want %0d %h/%h", it, wn, gp_out1, gp_out2, exp_we, m_out1, m_out2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rmw();
    test_poll();
    test_reject();
    test_backpressure();
    test_reset_mid_poll();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
